// File: rtl/axi_fifo_window_pkg.sv
// Shared types for the AXI FIFO window: response codes, FSM states, size helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package axi_fifo_window_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_st_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_st_t;

  // AXI size encoding (log2 of bytes per beat) for a full-width beat.
  function automatic logic [2:0] size_log2(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_fifo_window_if.sv
// AXI4 slave bundle for the FIFO window (AW/W/B/AR/R channels).
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready on every channel.
interface axi_fifo_window_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8
);
  logic [ID_W-1:0]     s_awid;
  logic [ADDR_W-1:0]   s_awaddr;
  logic [7:0]          s_awlen;
  logic [2:0]          s_awsize;
  logic [1:0]          s_awburst;
  logic                s_awvalid;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wlast;
  logic                s_wvalid;
  logic                s_wready;
  logic [ID_W-1:0]     s_bid;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;
  logic [ID_W-1:0]     s_arid;
  logic [ADDR_W-1:0]   s_araddr;
  logic [7:0]          s_arlen;
  logic [2:0]          s_arsize;
  logic [1:0]          s_arburst;
  logic                s_arvalid;
  logic                s_arready;
  logic [ID_W-1:0]     s_rid;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rlast;
  logic                s_rvalid;
  logic                s_rready;

  modport slave (
    input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bid, s_bresp, s_bvalid,
    input  s_bready,
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
    output s_arready,
    output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  s_rready
  );

  modport master (
    output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bid, s_bresp, s_bvalid,
    output s_bready,
    output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
    input  s_arready,
    input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    output s_rready
  );
endinterface

// File: rtl/axi_fifo_window_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Latency: push visible at rdata/empty one cycle later; rdata is the head with no extra delay.
// Backpressure: push ignored when full, pop ignored when empty; full/empty come from the registered count.
// Ports: clk, rst_n (async active-low), push/wdata in, pop in, rdata/empty/full/level out.
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign level = cnt_q;
  assign rdata = mem_q[rd_ptr_q];

  // full/empty are registered, so a pop while full frees no slot for a
  // same-cycle push, and a push into an empty FIFO cannot be popped that cycle.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    cnt_d    = cnt_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/axi_fifo_window.sv
// AXI4 slave mapping NUM_CH FIFOs into one window; writes push, reads pop the channel at addr[CH_LSB +: log2(NUM_CH)].
// Latency: push visible to reads/ch_empty 1 cycle after W handshake; ch_irq one register stage after ch_empty.
// Backpressure: writes never stall (beats to a full FIFO are dropped, SLVERR); reads never stall (empty -> zero data, SLVERR).
// Ports: clk, rst (async active-low), s (AXI4 slave modport), ch_empty/ch_full/ch_irq per-channel status.
// Optional: AXI_FIFO_WIN_LEVEL_CSR_EN makes addr[CH_LSB-1]=1 reads return the occupancy count; such writes get SLVERR.
module axi_fifo_window
  import axi_fifo_window_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8,
  parameter int DEPTH  = 64,
  parameter int NUM_CH = 2,
  parameter int CH_LSB = 12
) (
  input  logic              clk,
  input  logic              rst,
  axi_fifo_window_if.slave  s,
  output logic [NUM_CH-1:0] ch_empty,
  output logic [NUM_CH-1:0] ch_full,
  output logic [NUM_CH-1:0] ch_irq
);
  localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int         LVL_W    = $clog2(DEPTH) + 1;
  localparam logic [2:0] SIZE_LOG = size_log2(DATA_W);

  logic [DATA_W-1:0] fifo_rdata [NUM_CH];
  logic [LVL_W-1:0]  fifo_level [NUM_CH];
  logic [NUM_CH-1:0] fifo_empty, fifo_full, push_vec, pop_vec;

  wr_st_t            w_st_q, w_st_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [7:0]        w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [CH_W-1:0]   w_ch_q, w_ch_d;
  logic              w_size_ok_q, w_size_ok_d, w_err_q, w_err_d, w_lvl_q, w_lvl_d;
  logic              awready_q, awready_d, w_last_beat;

  rd_st_t            r_st_q, r_st_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [7:0]        r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [CH_W-1:0]   r_ch_q, r_ch_d;
  logic              r_size_ok_q, r_size_ok_d, r_lvl_q, r_lvl_d;
  logic              arready_q, arready_d, r_last_beat;

  logic [NUM_CH-1:0] irq_q;
  logic [CH_W-1:0]   aw_ch, ar_ch;
  logic              aw_lvl, ar_lvl;

  // Mask keeps the index in range when NUM_CH == 1 (field is still one bit wide).
  assign aw_ch = s.s_awaddr[CH_LSB +: CH_W] & CH_W'(NUM_CH - 1);
  assign ar_ch = s.s_araddr[CH_LSB +: CH_W] & CH_W'(NUM_CH - 1);

`ifdef AXI_FIFO_WIN_LEVEL_CSR_EN
  assign aw_lvl = s.s_awaddr[CH_LSB-1];
  assign ar_lvl = s.s_araddr[CH_LSB-1];
`else
  assign aw_lvl = 1'b0;
  assign ar_lvl = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sync_fifo_fwft #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (push_vec[g]),
      .pop   (pop_vec[g]),
      .wdata (s.s_wdata),
      .rdata (fifo_rdata[g]),
      .empty (fifo_empty[g]),
      .full  (fifo_full[g]),
      .level (fifo_level[g])
    );
  end

  assign ch_empty    = fifo_empty;
  assign ch_full     = fifo_full;
  assign ch_irq      = irq_q;
  assign s.s_awready = awready_q;
  assign s.s_arready = arready_q;
  assign s.s_bid     = w_id_q;
  assign s.s_rid     = r_id_q;

  // Write side: every beat is accepted; faulty beats are dropped and make the response SLVERR.
  always_comb begin
    w_st_d = w_st_q;  w_id_d = w_id_q;  w_len_d = w_len_q;  w_ch_d = w_ch_q;
    w_size_ok_d = w_size_ok_q;  w_err_d = w_err_q;  w_beat_d = w_beat_q;  w_lvl_d = w_lvl_q;
    push_vec = '0;  w_last_beat = (w_beat_q == w_len_q);
    s.s_wready = 1'b0;  s.s_bvalid = 1'b0;  s.s_bresp = OKAY;
    case (w_st_q)
      W_IDLE: if (s.s_awvalid && awready_q) begin
        w_id_d = s.s_awid;  w_len_d = s.s_awlen;  w_ch_d = aw_ch;  w_lvl_d = aw_lvl;
        w_size_ok_d = (s.s_awsize == SIZE_LOG);
        w_err_d = 1'b0;  w_beat_d = '0;  w_st_d = W_DATA;
      end
      W_DATA: begin
        s.s_wready = 1'b1;
        if (s.s_wvalid) begin
          if (w_size_ok_q && !w_lvl_q && (&s.s_wstrb) && !fifo_full[w_ch_q]) push_vec[w_ch_q] = 1'b1;
          else w_err_d = 1'b1;
          if (s.s_wlast != w_last_beat) w_err_d = 1'b1;
          w_beat_d = w_beat_q + 8'd1;
          // Burst length comes from awlen, not wlast, so a bad wlast cannot hang the FSM.
          if (w_last_beat) w_st_d = W_RESP;
        end
      end
      W_RESP: begin
        s.s_bvalid = 1'b1;
        s.s_bresp  = w_err_q ? SLVERR : OKAY;
        if (s.s_bready) w_st_d = W_IDLE;
      end
      default: w_st_d = W_IDLE;
    endcase
    awready_d = (w_st_d == W_IDLE);
  end

  // Read side: a beat is offered every cycle; unavailable data returns zero with SLVERR.
  always_comb begin
    r_st_d = r_st_q;  r_id_d = r_id_q;  r_len_d = r_len_q;  r_ch_d = r_ch_q;
    r_size_ok_d = r_size_ok_q;  r_beat_d = r_beat_q;  r_lvl_d = r_lvl_q;
    pop_vec = '0;  r_last_beat = 1'b0;
    s.s_rvalid = 1'b0;  s.s_rdata = '0;  s.s_rresp = OKAY;  s.s_rlast = 1'b0;
    case (r_st_q)
      R_IDLE: if (s.s_arvalid && arready_q) begin
        r_id_d = s.s_arid;  r_len_d = s.s_arlen;  r_ch_d = ar_ch;  r_lvl_d = ar_lvl;
        r_size_ok_d = (s.s_arsize == SIZE_LOG);
        r_beat_d = '0;  r_st_d = R_DATA;
      end
      R_DATA: begin
        r_last_beat = (r_beat_q == r_len_q);
        s.s_rvalid  = 1'b1;
        s.s_rlast   = r_last_beat;
        if (r_lvl_q) begin
          s.s_rdata = DATA_W'(fifo_level[r_ch_q]);
        end else if (r_size_ok_q && !fifo_empty[r_ch_q]) begin
          s.s_rdata = fifo_rdata[r_ch_q];
          pop_vec[r_ch_q] = s.s_rready;
        end else begin
          s.s_rresp = SLVERR;
        end
        if (s.s_rready) begin
          r_beat_d = r_beat_q + 8'd1;
          if (r_last_beat) r_st_d = R_IDLE;
        end
      end
      default: r_st_d = R_IDLE;
    endcase
    arready_d = (r_st_d == R_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_st_q <= W_IDLE;  w_id_q <= '0;  w_len_q <= '0;  w_ch_q <= '0;  w_size_ok_q <= 1'b0;
      w_err_q <= 1'b0;  w_beat_q <= '0;  w_lvl_q <= 1'b0;  awready_q <= 1'b0;
      r_st_q <= R_IDLE;  r_id_q <= '0;  r_len_q <= '0;  r_ch_q <= '0;  r_size_ok_q <= 1'b0;
      r_beat_q <= '0;  r_lvl_q <= 1'b0;  arready_q <= 1'b0;  irq_q <= '0;
    end else begin
      w_st_q <= w_st_d;  w_id_q <= w_id_d;  w_len_q <= w_len_d;  w_ch_q <= w_ch_d;  w_size_ok_q <= w_size_ok_d;
      w_err_q <= w_err_d;  w_beat_q <= w_beat_d;  w_lvl_q <= w_lvl_d;  awready_q <= awready_d;
      r_st_q <= r_st_d;  r_id_q <= r_id_d;  r_len_q <= r_len_d;  r_ch_q <= r_ch_d;  r_size_ok_q <= r_size_ok_d;
      r_beat_q <= r_beat_d;  r_lvl_q <= r_lvl_d;  arready_q <= arready_d;  irq_q <= ~fifo_empty;
    end
  end
endmodule
